// File: rtl/add_seq.sv
// add_seq: multi-cycle adder/subtractor. One CHUNK-bit ripple slice is reused
// over NCHUNK cycles, LSB chunk first, with the carry held in a register.
// Results and ALU flags (carry/borrow, signed overflow, zero, negative) are
// presented with a valid/ready handshake and stay put until the next result.
module add_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zr,
    output logic             ng,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("add_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE (and never while rst_n is low); out_valid
    // is high only in DONE. Once raised, out_valid and the result stay stable
    // until out_ready is seen, and in_valid is ignored outside IDLE.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already inverted for subtract
    logic             r_sub;
    logic [WIDTH-1:0] r_res;    // shadow result, filled chunk by chunk
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zr;
    logic             r_ng;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_res_next;

    // Shared ripple slice on the current chunk, plus the shadow result with
    // this chunk merged in.
    always_comb begin
        w_a_chunk  = r_a[r_k*CHUNK +: CHUNK];
        w_b_chunk  = r_b[r_k*CHUNK +: CHUNK];
        w_sum      = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        // Carry into the top bit of the slice, recovered from its sum bit.
        w_cmsb     = w_sum[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];
        w_res_next = r_res;
        w_res_next[r_k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // Control FSM and datapath registers; visible outputs load only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_res   <= '0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zr    <= 1'b0;
            r_ng    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_sub   <= sub;
                        r_carry <= sub ? ~cin : cin;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_sum[CHUNK];
                    r_k     <= r_k + 1'b1;
                    if (r_k == KW'(NCHUNK - 1)) begin
                        r_out   <= w_res_next;
                        r_cout  <= r_sub ^ w_sum[CHUNK];
                        r_ovf   <= w_cmsb ^ w_sum[CHUNK];
                        r_zr    <= (w_res_next == '0);
                        r_ng    <= w_res_next[WIDTH-1];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zr        = r_zr;
    assign ng        = r_ng;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: three builds (CHUNK=4, 16, 1) share operand inputs and
// each has its own handshake. Expected results come from integer arithmetic.
module tb_add_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_ready;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [15:0] res  [3];
  logic        co   [3];
  logic        of   [3];
  logic        zf   [3];
  logic        nf   [3];
  logic [1:0]  st   [3];

  int nch [3] = '{4, 1, 16};
  int vectors;
  int miscompares;
  logic [19:0] exp_q [$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  add_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
    .out(res[0]), .cout(co[0]), .ovf(of[0]), .zr(zf[0]), .ng(nf[0]), .dbg_state(st[0])
  );
  add_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
    .out(res[1]), .cout(co[1]), .ovf(of[1]), .zr(zf[1]), .ng(nf[1]), .dbg_state(st[1])
  );
  add_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
    .out(res[2]), .cout(co[2]), .ovf(of[2]), .zr(zf[2]), .ng(nf[2]), .dbg_state(st[2])
  );

  // observed result bundle {cout, ovf, zr, ng, out}
  function automatic logic [19:0] got(input int u);
    return {co[u], of[u], zf[u], nf[u], res[u]};
  endfunction

  // reference: plain unsigned and signed integer arithmetic
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic c);
    int ux, uy, sx, sy, r, ur;
    logic [15:0] o;
    logic cf, vf;
    ux = int'({16'd0, x});
    uy = int'({16'd0, y});
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      ur = ux + uy + int'(c);
      cf = (ur > 65535);
      r  = sx + sy + int'(c);
    end else begin
      ur = ux - uy - int'(c);
      cf = (ux < uy + int'(c));
      r  = sx - sy - int'(c);
    end
    o  = ur[15:0];
    vf = (r > 32767) || (r < -32768);
    return {cf, vf, (o == 16'd0), o[15], o};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // driver: one operation on unit u; checks ready, latency and result.
  // With hold set, out_ready stays low and the result is left in DONE.
  task automatic run_op(input int u, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic ts, input logic tc, input logic [19:0] e_in,
                        input bit hold);
    int lat;
    int guard;
    logic [19:0] e;
    a = ta; b = tbv; sub = ts; cin = tc;
    out_ready = !hold;
    iv[u] = 1'b1;
    guard = 0;
    while (ir[u] !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    vectors++;
    if (ir[u] !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready u=%0d got=%b exp=1", u, ir[u]);
    end
    @(posedge clk); #1;
    exp_q.push_back(e_in);
    iv[u] = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    lat = 0;
    while (ov[u] !== 1'b1 && lat < 40) begin
      vectors++;
      if (ir[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL run_in_ready u=%0d cyc=%0d got=%b exp=0", u, lat, ir[u]);
      end
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat != nch[u]) begin
      miscompares++;
      $display("FAIL latency u=%0d got=%0d exp=%0d", u, lat, nch[u]);
    end
    e = exp_q.pop_front();
    vectors++;
    if (got(u) !== e) begin
      miscompares++;
      $display("FAIL result u=%0d op=%h%s%h+c%0d got=%h exp=%h", u, ta, ts ? "-" : "+",
               tbv, tc, got(u), e);
    end
    if (!hold) begin
      @(posedge clk); #1;
      vectors++;
      if (ov[u] !== 1'b0 || ir[u] !== 1'b1 || got(u) !== e) begin
        miscompares++;
        $display("FAIL release u=%0d got_ov=%b got_ir=%b got=%h exp_ov=0 exp_ir=1 exp=%h",
                 u, ov[u], ir[u], got(u), e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0;
    for (int u = 0; u < 3; u++) iv[u] = 1'b0;
    a = 16'h0; b = 16'h0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      vectors++;
      if (ov[u] !== 1'b0 || ir[u] !== 1'b0 || got(u) !== 20'h0) begin
        miscompares++;
        $display("FAIL reset_state u=%0d got_ov=%b got_ir=%b got=%h exp=0/0/00000",
                 u, ov[u], ir[u], got(u));
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      vectors++;
      if (ir[u] !== 1'b1 || ov[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release u=%0d got_ir=%b got_ov=%b exp=1/0", u, ir[u], ov[u]);
      end
    end
  endtask

  task automatic test_add();
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, {4'b0000, 16'h2345}, 0);
  endtask

  task automatic test_wrap();
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, {4'b1010, 16'h0000}, 0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, {4'b0101, 16'h8000}, 0);
  endtask

  task automatic test_sub();
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, {4'b1001, 16'hFFFE}, 0);
    run_op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, {4'b0000, 16'h000E}, 0);
  endtask

  task automatic test_backpressure();
    logic [19:0] snap;
    snap = {4'b0000, 16'h0007};
    run_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, snap, 1);
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'(i % 2);
      a = 16'($urandom); b = 16'($urandom); sub = 1'(i % 2); cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      vectors++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || got(0) !== snap) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc=%0d got_ov=%b got_ir=%b got=%h exp=1/0/%h",
                 i, ov[0], ir[0], got(0), snap);
      end
    end
    iv[0] = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || got(0) !== snap) begin
      miscompares++;
      $display("FAIL backpressure_release got_ov=%b got_ir=%b got=%h exp=0/1/%h",
               ov[0], ir[0], got(0), snap);
    end
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, {4'b0000, 16'h0100}, 0);
  endtask

  task automatic test_reset_mid_run();
    int guard;
    a = 16'h4000; b = 16'h4000; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1; iv[0] = 1'b1;
    guard = 0;
    while (ir[0] !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b0 || got(0) !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid_run got_ov=%b got_ir=%b got=%h exp=0/0/00000",
               ov[0], ir[0], got(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_release got_ov=%b got_ir=%b exp=0/1", ov[0], ir[0]);
    end
    run_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, {4'b0000, 16'h0003}, 0);
  endtask

  task automatic test_sweep();
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, {4'b1000, 16'h0001}, 0);
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1, {4'b1000, 16'h0001}, 0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, {4'b1000, 16'h0001}, 0);
  endtask

  task automatic test_random();
    int u;
    logic [15:0] ta, tbv;
    logic ts, tc;
    for (int i = 0; i < 1000; i++) begin
      u   = $urandom_range(0, 2);
      ta  = pick();
      tbv = pick();
      ts  = 1'($urandom_range(0, 1));
      tc  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(u, ta, tbv, ts, tc, model(ta, tbv, ts, tc), 0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int u = 0; u < 3; u++) iv[u] = 1'b0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
